// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD counter/display slice: digit width,
// 7-segment patterns {A,B,C,D,E,F,G} (active-high) and helpers.
package bcd_display_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Clamp a raw nibble into the legal BCD range (anything above 9 becomes 9).
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control/status bundle of the BCD counter display.
// master drives the control strobes; slave is the counter itself.
interface bcd_counter_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import bcd_display_pkg::*;

  logic                          Enable;
  logic                          UpDown;
  logic                          Load;
  logic [DIGIT_W*NUM_DIGITS-1:0] LoadValue;
  logic [DIGIT_W*NUM_DIGITS-1:0] Count;
  logic                          Tick;
  logic                          Carry;
  logic [NUM_DIGITS-1:0]         DigitSel;
  logic [SEG_W-1:0]              Seg;

  modport master (
    output Enable, UpDown, Load, LoadValue,
    input  Count, Tick, Carry, DigitSel, Seg
  );

  modport slave (
    input  Enable, UpDown, Load, LoadValue,
    output Count, Tick, Carry, DigitSel, Seg
  );

endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to 7-segment decoder; blank flag or a
// non-decimal nibble yields a dark digit.
module bcd_seg_decode
  import bcd_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  // Pattern lookup
  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with tick divider and multiplexed
// 7-segment display scan.
// Optional build macro: BCD_DISPLAY_BLANK_EN -- blank leading zeros
// above the most-significant nonzero digit (digit 0 always shown).
module bcd_counter_display
  import bcd_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DIV_COUNT     = 5,
  parameter int unsigned REFRESH_COUNT = 4,
  parameter int unsigned WRAP          = 1
) (
  input logic                  Clk,
  input logic                  Rst,
  bcd_counter_display_if.slave bus
);

  localparam int unsigned CNT_W  = DIGIT_W * NUM_DIGITS;
  localparam int unsigned DIV_W  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned REF_W  = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int unsigned SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_COUNT - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_COUNT - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

  // Divider
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_next;
  logic             tick_q;

  // Counter
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   inc_val;
  logic [CNT_W-1:0]   dec_val;
  logic [CNT_W-1:0]   load_val;
  logic               all_nine;
  logic               all_zero;
  logic               inc_ripple;
  logic               dec_borrow;
  logic [DIGIT_W-1:0] cur_digit;
  logic               carry_q;
  logic               carry_next;

  // Display scan
  logic [REF_W-1:0]      ref_q;
  logic [REF_W-1:0]      ref_next;
  logic [SCAN_W-1:0]     scan_q;
  logic [SCAN_W-1:0]     scan_next;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [SEG_W-1:0]      seg_q;
  logic [SEG_W-1:0]      seg_next;
  logic [DIGIT_W-1:0]    shown_digit;
  logic                  shown_blank;

  // Divider next value: 0..DIV_COUNT-1 then back to 0
  always_comb begin
    div_next = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Divider and tick registers; tick is high while the divider holds its last value
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_next;
      tick_q <= (div_next == DIV_LAST);
    end
  end

  // BCD ripple increment/decrement, limit detection and clamped load value
  always_comb begin
    inc_val    = count_q;
    dec_val    = count_q;
    load_val   = '0;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    inc_ripple = 1'b1;
    dec_borrow = 1'b1;
    cur_digit  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      cur_digit = count_q[i*DIGIT_W +: DIGIT_W];
      if (cur_digit != DIGIT_MAX) begin
        all_nine = 1'b0;
      end
      if (cur_digit != '0) begin
        all_zero = 1'b0;
      end
      if (inc_ripple) begin
        if (cur_digit == DIGIT_MAX) begin
          inc_val[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          inc_val[i*DIGIT_W +: DIGIT_W] = cur_digit + DIGIT_W'(1);
          inc_ripple = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (cur_digit == '0) begin
          dec_val[i*DIGIT_W +: DIGIT_W] = DIGIT_MAX;
        end else begin
          dec_val[i*DIGIT_W +: DIGIT_W] = cur_digit - DIGIT_W'(1);
          dec_borrow = 1'b0;
        end
      end
      load_val[i*DIGIT_W +: DIGIT_W] = clamp_digit(bus.LoadValue[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next count: load beats a ticked step, otherwise hold; limits wrap or saturate
  always_comb begin
    count_next = count_q;
    carry_next = 1'b0;
    if (bus.Load) begin
      count_next = load_val;
    end else if (tick_q && bus.Enable) begin
      if (bus.UpDown) begin
        carry_next = all_nine;
        if (!all_nine || (WRAP != 0)) begin
          count_next = inc_val;
        end
      end else begin
        carry_next = all_zero;
        if (!all_zero || (WRAP != 0)) begin
          count_next = dec_val;
        end
      end
    end
  end

  // Count and carry registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_next;
      carry_q <= carry_next;
    end
  end

  // Scan position: dwell REFRESH_COUNT cycles per digit, digit 0 upward
  always_comb begin
    ref_next  = ref_q + REF_W'(1);
    scan_next = scan_q;
    if (ref_q == REF_LAST) begin
      ref_next  = '0;
      scan_next = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end
  end

  // Digit fed to the decoder and its one-hot enable, both for the upcoming scan slot
  always_comb begin
    shown_digit = count_q[32'(scan_next)*DIGIT_W +: DIGIT_W];
    sel_next    = NUM_DIGITS'(1) << scan_next;
  end

`ifdef BCD_DISPLAY_BLANK_EN
  logic upper_nonzero;

  // Blank a digit when it and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    upper_nonzero = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= 32'(scan_next)) && (count_q[i*DIGIT_W +: DIGIT_W] != '0)) begin
        upper_nonzero = 1'b1;
      end
    end
    shown_blank = (scan_next != '0) && !upper_nonzero;
  end
`else
  assign shown_blank = 1'b0;
`endif

  bcd_seg_decode u_seg_decode (
    .digit (shown_digit),
    .blank (shown_blank),
    .seg_c (seg_next)
  );

  // Scan registers; DigitSel and Seg update together
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ref_q  <= '0;
      scan_q <= '0;
      sel_q  <= NUM_DIGITS'(1);
      seg_q  <= SEG_0;
    end else begin
      ref_q  <= ref_next;
      scan_q <= scan_next;
      sel_q  <= sel_next;
      seg_q  <= seg_next;
    end
  end

  assign bus.Count    = count_q;
  assign bus.Tick     = tick_q;
  assign bus.Carry    = carry_q;
  assign bus.DigitSel = sel_q;
  assign bus.Seg      = seg_q;

endmodule

// File: doc/bcd_counter_display.md
BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of BCD digits (range 1..8).
REQ-002 Parameter DIV_COUNT, default 5, Clk cycles per count tick (>=1).
REQ-003 Parameter REFRESH_COUNT, default 4, Clk cycles each digit is displayed (>=1).
REQ-004 Parameter WRAP, default 1: 1 = wrap-around at the limits; 0 = saturate at the limits.
REQ-005 Clk  input  1  system clock; all state updates on the rising edge.
REQ-006 Rst  input  1  asynchronous, active-high reset.
REQ-007 Enable  input  1  count enable, sampled on tick cycles.
REQ-008 UpDown  input  1  1 = count up, 0 = count down.
REQ-009 Load  input  1  synchronous parallel load strobe.
REQ-010 LoadValue  input  4*NUM_DIGITS  BCD load value; digit 0 is bits [3:0].
REQ-011 Count  output  4*NUM_DIGITS  current BCD count.
REQ-012 Tick  output  1  one-Clk pulse at each divider terminal count.
REQ-013 Carry  output  1  one-Clk pulse when a step hits a limit.
REQ-014 DigitSel  output  NUM_DIGITS  one-hot active-high digit enable.
REQ-015 Seg  output  7  segments {A,B,C,D,E,F,G}, active-high.

Function
REQ-016 Divider: counts 0..DIV_COUNT-1, then returns to 0; Tick=1 in the cycle the divider holds DIV_COUNT-1; DIV_COUNT=1 gives Tick held at 1.
REQ-017 Priority per Clk edge: Load > (Tick & Enable) step > hold.
REQ-018 Load writes LoadValue to Count on the next edge, independent of Tick; any digit >9 is written as 9; divider is not disturbed.
REQ-019 Step up: BCD ripple increment (digit 9 -> 0 with carry into next digit); step down: BCD ripple decrement (digit 0 -> 9 with borrow).
REQ-020 Limit up (all digits 9): WRAP=1 -> Count becomes all 0; WRAP=0 -> Count holds. Carry=1 for the following cycle in both cases.
REQ-021 Limit down (all digits 0): WRAP=1 -> Count becomes all 9; WRAP=0 -> Count holds. Carry=1 for the following cycle.
REQ-022 Carry is registered, 1 cycle wide, never asserted by Load.
REQ-023 Refresh: scan counter advances DigitSel every REFRESH_COUNT cycles in order digit 0,1,...,NUM_DIGITS-1, then digit 0.
REQ-024 Seg and DigitSel are registered together; Seg shows the 7-segment pattern of the digit currently selected by DigitSel, using Count as of the previous cycle (latency 1 Clk).
REQ-025 Patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.

Reset
REQ-026 On Rst=1, immediately: Count=0, divider=0, scan=0, Tick=0, Carry=0, DigitSel=000..01, Seg=1111110.
REQ-027 Rst asserted mid-step or mid-load discards that operation; first Tick after release occurs DIV_COUNT cycles after the first Clk edge with Rst=0.

Configuration
REQ-028 Macro BCD_DISPLAY_BLANK_EN defined: Seg=0000000 for any digit above the most-significant nonzero digit; digit 0 is never blanked (count 0 shows "0").
REQ-029 BCD_DISPLAY_BLANK_EN undefined: every digit is displayed, including leading zeros.

Structure
REQ-030 Package bcd_display_pkg holds the digit-width constant (4), the ten segment-pattern constants, and the blank pattern.
REQ-031 Sub-module bcd_seg_decode: combinational 4-bit digit + blank flag -> 7-bit Seg; values >9 decode to blank.

Verification (NUM_DIGITS=2, DIV_COUNT=4, REFRESH_COUNT=2 unless stated)
REQ-032 Rst pulse, Enable=1, UpDown=1 for 40 Clk -> Tick every 4th Clk, Count 00->01->...->10; digit-1 rollover 09->10 verified.
REQ-033 Load LoadValue=0x98 then count up, WRAP=1 -> 98, 99, 00 with Carry pulse 1 cycle; WRAP=0 -> 99 holds, Carry pulse on each tick at limit.
REQ-034 From 00 count down -> WRAP=1 gives 99 with Carry; WRAP=0 holds 00 with Carry.
REQ-035 Load 0xFA -> Count=0x99; Load asserted same cycle as Tick&Enable -> loaded value wins, no step.
REQ-036 Count=07, observe scan -> DigitSel 01,01,10,10,01...; Seg=1110000 when digit 0 selected; digit 1 Seg=1111110 (macro off) or 0000000 (BLANK_EN on).
REQ-037 Assert Rst asynchronously between edges mid-count -> all outputs reach reset values before the next Clk edge.
